instruction_fetch: RTL and testbench

Upstream stage of the control unit: walks the program memory with an 8-bit program counter, reads three consecutive bytes (opcode, operand 1, operand 2) and assembles them into the 24-bit instruction word that the control unit decodes. It presents the word with a valid/ready handshake, supports an absolute jump redirect, and stops permanently on a halt opcode until reset.

---
 rtl/instruction_fetch.sv | 112 +++++++++++
 tb/tb_instruction_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads opcode/operand bytes from program memory and
// presents an assembled 24-bit instruction word over a valid/ready handshake.
module instruction_fetch #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [7:0]        HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [23:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    RD0   = 3'd0,
    RD1   = 3'd1,
    RD2   = 3'd2,
    LAST  = 3'd3,
    VALID = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] opcode_q, op1_q;
  logic       jump_take;
  logic       accept;
  logic       is_halt;

  // A jump is ignored once halted; only reset leaves HALT.
  assign jump_take = jump_en && (state != HALT);
  assign accept    = (state == VALID) && instr_valid && instr_ready;
  assign is_halt   = (instr[23:16] == HALT_OPCODE);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = pc;
    case (state)
      RD0: begin
        if (enable) begin
          mem_rd    = 1'b1;
          state_nxt = RD1;
        end
      end
      RD1: begin
        mem_rd    = 1'b1;
        mem_addr  = pc + ADDR_W'(1);
        state_nxt = RD2;
      end
      RD2: begin
        mem_rd    = 1'b1;
        mem_addr  = pc + ADDR_W'(2);
        state_nxt = LAST;
      end
      LAST:  state_nxt = VALID;
      VALID: if (accept) state_nxt = is_halt ? HALT : RD0;
      HALT:  state_nxt = HALT;
      default: state_nxt = RD0;
    endcase
    if (jump_take) state_nxt = RD0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RD0;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      opcode_q    <= '0;
      op1_q       <= '0;
    end else begin
      state <= state_nxt;
      if (jump_take) begin
        pc          <= jump_addr;
        instr_valid <= 1'b0;
      end else begin
        case (state)
          RD1:  opcode_q <= mem_data;
          RD2:  op1_q    <= mem_data;
          LAST: begin
            instr       <= {opcode_q, op1_q, mem_data};
            instr_valid <= 1'b1;
          end
          VALID: begin
            if (accept) begin
              instr_valid <= 1'b0;
              // The halting word keeps its pc; nothing follows it.
              if (is_halt) halted <= 1'b1;
              else         pc     <= pc + ADDR_W'(3);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a byte-array memory model, a scoreboard
// of expected {instr, pc} words, and a monitor that pops on each handshake.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [23:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic [7:0]  pc;
  logic        halted;

  logic [7:0]  mem [256];
  logic [31:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .halted      (halted)
  );

  initial forever #5 clk = ~clk;

  // Synchronous program memory: data appears one cycle after the read strobe.
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready && !jump_en) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_instr: got %h pc %h, nothing expected", instr, pc);
      end else begin
        check("scoreboard", {instr, pc}, exp_q.pop_front());
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [7:0] a);
    step();
    jump_en   = 1'b1;
    jump_addr = a;
    step();
    jump_en   = 1'b0;
  endtask

  // Waits for one handshake; returns just after the accepting clock edge.
  task automatic wait_accept(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready && !jump_en) seen = 1'b1;
      step();
    end
    check("accept_in_time", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h05; mem[8'h02] = 8'h2A;
    mem[8'h03] = 8'hFF; mem[8'h04] = 8'h00; mem[8'h05] = 8'h00;
    mem[8'h10] = 8'h07; mem[8'h11] = 8'h08; mem[8'h12] = 8'h09;
    mem[8'h20] = 8'hAA; mem[8'h21] = 8'hBB; mem[8'h22] = 8'hCC;
    mem[8'h40] = 8'h12; mem[8'h41] = 8'h34; mem[8'h42] = 8'h56;
    mem[8'hFE] = 8'h03; mem[8'hFF] = 8'h11;
    mem_data    = 8'h00;
    reset       = 1'b1;
    enable      = 1'b0;
    instr_ready = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 8'h00;
    step(); step();
    reset = 1'b0;

    // Reset state and enable gating from reset.
    @(negedge clk);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h00);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); @(negedge clk);
      if (mem_rd !== 1'b0) ok = 1'b0;
    end
    check("disabled_no_read", 32'(ok), 32'd1);

    // Run from pc 0; enable drops in RD1 yet the word still completes.
    step();
    enable = 1'b1; instr_ready = 1'b1;
    exp_q.push_back({24'h01052A, 8'h00});
    @(negedge clk);
    check("c0_rd_addr", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h00});
    step(); enable = 1'b0;
    @(negedge clk);
    check("c1_rd_addr", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h01});
    step(); @(negedge clk);
    check("c2_rd_addr", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h02});
    step(); @(negedge clk);
    check("c3_no_rd", 32'(mem_rd), 32'd0);
    step(); @(negedge clk);
    check("c4_valid", {7'd0, instr_valid, instr}, {7'd0, 1'b1, 24'h01052A});
    check("c4_pc", 32'(pc), 32'h00);
    step(); @(negedge clk);
    check("c5_pc_addr", {pc, mem_addr}, 32'h0303);
    check("c5_valid_low", 32'(instr_valid), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); @(negedge clk);
      if (mem_rd !== 1'b0 || pc !== 8'h03) ok = 1'b0;
    end
    check("enable_low_waits", 32'(ok), 32'd1);

    // Backpressure: word at 0x10 held for 6 cycles.
    instr_ready = 1'b0;
    do_jump(8'h10);
    enable = 1'b1;
    exp_q.push_back({24'h070809, 8'h10});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_valid) break;
      step();
    end
    check("bp_valid", 32'(instr_valid), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); @(negedge clk);
      if (instr !== 24'h070809 || pc !== 8'h10 || mem_rd !== 1'b0 || instr_valid !== 1'b1)
        ok = 1'b0;
    end
    check("bp_stable", 32'(ok), 32'd1);
    step(); instr_ready = 1'b1;
    @(negedge clk);
    step(); @(negedge clk);
    check("bp_next_fetch", {15'd0, instr_valid, mem_rd, pc, mem_addr}, {15'd0, 1'b0, 1'b1, 8'h13, 8'h13});

    // Address wrap at the top of memory.
    mem[8'h00] = 8'h22;
    do_jump(8'hFE);
    exp_q.push_back({24'h031122, 8'hFE});
    @(negedge clk);
    check("wrap_addr0", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'hFE});
    step(); @(negedge clk);
    check("wrap_addr1", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'hFF});
    step(); @(negedge clk);
    check("wrap_addr2", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h00});
    step();
    wait_accept(6);
    @(negedge clk);
    check("wrap_next_pc", {pc, mem_addr}, 32'h0101);
    mem[8'h00] = 8'h01;

    // Jump while in RD2 aborts the word at 0x20.
    do_jump(8'h20);
    step(); step();
    jump_en = 1'b1; jump_addr = 8'h40;
    @(negedge clk);
    check("mid_in_rd2", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h22});
    step(); jump_en = 1'b0;
    exp_q.push_back({24'h123456, 8'h40});
    @(negedge clk);
    check("mid_redirect", {22'd0, instr_valid, mem_rd, mem_addr}, {22'd0, 1'b0, 1'b1, 8'h40});
    step();
    wait_accept(8);

    // Normal word then halt word; halt ignores jumps, reset beats jump.
    do_jump(8'h00);
    exp_q.push_back({24'h01052A, 8'h00});
    exp_q.push_back({24'hFF0000, 8'h03});
    wait_accept(8);
    wait_accept(8);
    @(negedge clk);
    check("halt_state", {29'd0, halted, mem_rd, instr_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
    step();
    jump_en = 1'b1; jump_addr = 8'h55;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (halted !== 1'b1 || mem_rd !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h03) ok = 1'b0;
      step();
    end
    check("halt_ignores_jump", 32'(ok), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; jump_en = 1'b0;
    @(negedge clk);
    check("reset_wins", {14'd0, halted, instr_valid, mem_rd, pc, mem_addr}, {14'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00});
    step();
    enable = 1'b0; instr_ready = 1'b0;
    step(); step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
